// File: rtl/seed_uart_tx.sv
// seed_uart_tx
// Buffers seed bytes from the random seed generator in a 4-entry FIFO and
// sends each one as an 8N1 UART frame (LSB first, idle-high line).
// Frames go back to back while the FIFO holds data.
// Seeds that arrive while the FIFO is full are dropped. Drops set a sticky
// overflow flag and are counted in a saturating 8-bit counter.

module seed_uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    input  logic       seed_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] drop_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

    // frame sequencer state
    logic [1:0] state_r;
    logic [7:0] cyc_cnt_r;
    logic [2:0] bit_idx_r;
    logic [7:0] shift_r;
    logic       tx_r;

    // FIFO state
    logic [7:0] fifo_mem_r [0:3];
    logic [1:0] wr_ptr_r;
    logic [1:0] rd_ptr_r;
    logic [2:0] count_r;

    // status
    logic       overflow_r;
    logic [7:0] drop_count_r;

    // per-edge decisions
    logic       last_cyc_s;
    logic       fifo_empty_s;
    logic       fifo_full_s;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;
    logic [2:0] next_bit_s;
    logic [7:0] head_s;

    // Work out this edge's pop, push and drop from the pre-edge state.
    // A full FIFO still takes a push when a pop happens on the same edge.
    always_comb begin
        last_cyc_s   = (cyc_cnt_r == LAST_CYC);
        fifo_empty_s = (count_r == 3'd0);
        fifo_full_s  = (count_r == FULL_CNT);
        next_bit_s   = bit_idx_r + 3'd1;
        head_s       = fifo_mem_r[rd_ptr_r];
        pop_s        = 1'b0;
        if (fifo_empty_s) begin
            pop_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            pop_s = 1'b1;
        end else if ((state_r == ST_STOP) && last_cyc_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        push_s = seed_ready && (!fifo_full_s || pop_s);
        drop_s = seed_ready && fifo_full_s && !pop_s;
    end

    // Circular buffer storage, modulo-4 pointers and occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= seed;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT long
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cyc_cnt_r <= 8'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cyc_cnt_r <= 8'd0;
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= head_s;
                        state_r <= ST_START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (last_cyc_s) begin
                        state_r   <= ST_DATA;
                        cyc_cnt_r <= 8'd0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (last_cyc_s) begin
                        cyc_cnt_r <= 8'd0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= next_bit_s;
                            tx_r      <= shift_r[next_bit_s];
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 8'd1;
                    end
                end
                ST_STOP: begin
                    if (last_cyc_s) begin
                        cyc_cnt_r <= 8'd0;
                        bit_idx_r <= 3'd0;
                        // chain straight into the next frame when data is waiting
                        if (pop_s) begin
                            shift_r <= head_s;
                            state_r <= ST_START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cyc_cnt_r <= 8'd0;
                    bit_idx_r <= 3'd0;
                    tx_r      <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 8'hFF) begin
                    drop_count_r <= drop_count_r + 8'd1;
                end
            end
        end
    end

    // Busy covers both a frame on the line and data still waiting in the FIFO
    always_comb begin
        busy = (state_r != ST_IDLE) || (count_r != 3'd0);
    end

    assign tx         = tx_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_seed_uart_tx.sv
// Bench for seed_uart_tx with CLKS_PER_BIT = 4.
// The reference model keeps the accepted bytes in a queue and records when the
// current frame started. It derives the expected line level from the offset
// into that frame.

module tb_seed_uart_tx;

    localparam int C = 4;

    logic       clk;
    logic       reset;
    logic [7:0] seed;
    logic       seed_ready;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [7:0] drop_count;

    int n_tests  = 0;
    int n_fail   = 0;
    int busy_cnt = 0;

    seed_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .seed_ready (seed_ready),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [7:0] mq [$];
    bit         m_active = 1'b0;
    int         m_start  = 0;
    int         m_edge   = 0;
    logic [7:0] m_cur    = 8'd0;
    bit         m_ovf    = 1'b0;
    int         m_drops  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %0h, expected %0h", name, m_edge, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_active = 1'b0;
        m_start  = 0;
        m_ovf    = 1'b0;
        m_drops  = 0;
    endfunction

    // One rising edge of the model. The FIFO must be full and no byte leave
    // on this edge for a push to be dropped.
    function automatic void model_edge(input bit rdy, input logic [7:0] s);
        int sz;
        bit pop;
        m_edge++;
        sz  = mq.size();
        pop = 1'b0;
        if (m_active && ((m_edge - m_start) == 10 * C)) m_active = 1'b0;
        if (!m_active && sz > 0) begin
            pop      = 1'b1;
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_start  = m_edge;
        end
        if (rdy) begin
            if (sz < 4 || pop) begin
                mq.push_back(s);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endfunction

    function automatic logic model_tx();
        int ph;
        if (!m_active) return 1'b1;
        ph = (m_edge - m_start) / C;
        if (ph == 0) return 1'b0;
        if (ph <= 8) return m_cur[ph - 1];
        return 1'b1;
    endfunction

    // Entered at a falling edge: drive, clock once, compare against the model
    task automatic step(input bit rdy, input logic [7:0] s);
        seed_ready = rdy;
        seed       = s;
        @(posedge clk);
        model_edge(rdy, s);
        #1;
        check("tx", 32'(tx), 32'(model_tx()));
        check("busy", 32'(busy), 32'(m_active || (mq.size() > 0)));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
    endtask

    // Entered at a falling edge: assert reset between edges, check the forced
    // values at once, then release on a later falling edge
    task automatic do_reset();
        #1;
        reset      = 1'b0;
        seed_ready = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit         rdy;
        logic [7:0] sd;
        int         n;
        bit         etx;
        bit         ebusy;
    } vec_t;

    vec_t vt [12];
    bit   exp_bits [8];
    int   pct;

    initial begin
        reset      = 1'b1;
        seed_ready = 1'b0;
        seed       = 8'd0;

        // single 0xA5 frame: expected line levels per phase
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[0]  = '{1'b1, 8'hA5, 1, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 8'h00, C, 1'b0, 1'b1};
        for (int b = 0; b < 8; b++) begin
            vt[2 + b] = '{1'b0, 8'h00, C, exp_bits[b], 1'b1};
        end
        vt[10] = '{1'b0, 8'h00, C, 1'b1, 1'b1};
        vt[11] = '{1'b0, 8'h00, 3, 1'b1, 1'b0};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vt[i].n; k++) begin
                step(vt[i].rdy && (k == 0), vt[i].sd);
                check("a5_tx", 32'(tx), 32'(vt[i].etx));
                check("a5_busy", 32'(busy), 32'(vt[i].ebusy));
            end
        end

        // back-to-back frames 0x01, 0x02, 0x03
        busy_cnt = 0;
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        for (int i = 0; i < 125; i++) step(1'b0, 8'h00);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd121);
        check("b2b_overflow", 32'(overflow), 32'd0);

        // overflow: ten consecutive seeds during the first frame
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 210; i++) step(1'b0, 8'h00);
        check("ovf_drop_count", 32'(drop_count), 32'd5);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_busy_cycles", 32'(busy_cnt), 32'd201);

        // push on the same edge as the stop-end pop with four entries queued
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i));
        for (int i = 0; i < 36; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h45);
        check("same_edge_no_drop", 32'(drop_count), 32'd0);
        step(1'b1, 8'h46);
        check("full_drop", 32'(drop_count), 32'd1);
        for (int i = 0; i < 260; i++) step(1'b0, 8'h00);

        // reset during data bit 3, then a clean 0x3C frame
        do_reset();
        step(1'b1, 8'h77);
        for (int i = 0; i < 18; i++) step(1'b0, 8'h00);
        do_reset();
        busy_cnt = 0;
        step(1'b1, 8'h3C);
        for (int i = 0; i < 50; i++) step(1'b0, 8'h00);
        check("post_rst_busy_cycles", 32'(busy_cnt), 32'd41);

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 330; i++) step(1'b1, 8'($urandom));
        check("sat_drop_count", 32'(drop_count), 32'd255);
        check("sat_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 210; i++) step(1'b0, 8'h00);

        // randomized traffic at three push densities
        do_reset();
        for (int seg = 0; seg < 3; seg++) begin
            pct = (seg == 0) ? 10 : ((seg == 1) ? 40 : 90);
            for (int i = 0; i < 1000; i++) begin
                step($urandom_range(0, 99) < 32'(pct), 8'($urandom));
            end
        end
        for (int i = 0; i < 220; i++) step(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seed_uart_tx.md
SEED_UART_TX -- requirements
Module: seed_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of seed entries buffered; fixed at 4 for this revision.
REQ-003 SHALL have port clk  input  1  single system clock (10 kHz LFOSC domain); all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port seed  input  8  seed byte from the upstream random seed generator.
REQ-006 SHALL have port seed_ready  input  1  seed valid strobe; each clk edge sampled high is one push request.
REQ-007 SHALL have port tx  output  1  UART serial line, idle high, 8N1, LSB first.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 SHALL have port overflow  output  1  sticky flag, set on the first dropped seed.
REQ-010 SHALL have port drop_count  output  8  number of dropped seeds, saturating.

Function
REQ-011 SHALL write seed into the FIFO on every clk edge where seed_ready=1 and the FIFO is not full.
- "Full" is evaluated before this edge's pop.
- Exception: when count=4 and a pop occurs on the same edge, the push is accepted and count stays 4.
REQ-012 SHALL drop the seed on an edge where seed_ready=1, count=4 and no pop occurs.
- overflow goes to 1.
- drop_count increments, saturating at 255 (no wrap).
REQ-013 SHALL implement the FIFO as a circular buffer with 2-bit read/write pointers (modulo-4 wrap) and a 3-bit count (0..4).
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; each of START and STOP lasts exactly CLKS_PER_BIT cycles.
REQ-015 SHALL, in IDLE with count>0, pop the head entry into an 8-bit shift register on that edge, enter START, and drive tx=0 from that edge.
REQ-016 SHALL, in DATA, drive shift-register bits 0..7 in order, each for CLKS_PER_BIT cycles, using a 3-bit bit index.
REQ-017 SHALL, in STOP, drive tx=1 for CLKS_PER_BIT cycles.
REQ-018 SHALL, at the last STOP cycle, take one of two paths:
- count>0: pop the next entry and enter START directly (no extra idle cycle).
- count=0: enter IDLE.
REQ-019 SHALL register tx (no combinational path from any input to tx).
REQ-020 SHALL make the latency from an accepting edge (empty FIFO, FSM in IDLE) to the tx falling edge exactly one clk cycle.
REQ-021 SHALL make each frame exactly 10*CLKS_PER_BIT cycles long.
REQ-022 SHALL derive busy combinationally as (state != IDLE) or (count != 0).
REQ-023 SHALL treat the seed byte as opaque data and never alter it.

Reset
REQ-024 SHALL, while reset=0, asynchronously force the following values, independent of clk:
- tx=1, busy=0, overflow=0, drop_count=0.
- FSM in IDLE; FIFO pointers and count at 0; bit and cycle counters at 0.
REQ-025 SHALL abort any frame in progress on reset assertion: tx returns high immediately and buffered seeds are discarded.
REQ-026 SHALL clear overflow and drop_count only by reset.
REQ-027 SHALL accept pushes from the first clk edge after reset deasserts.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL check a single seed:
- Stimulus: seed=0xA5, one-cycle seed_ready.
- Required: tx low one cycle later for 4 cycles; data 1,0,1,0,0,1,0,1 at 4 cycles each; high for 4 cycles; frame 40 cycles total; busy falls after the stop bit.
REQ-029 SHALL check back-to-back frames:
- Stimulus: seeds 0x01, 0x02, 0x03 on consecutive cycles.
- Required: three contiguous 40-cycle frames with no gap; bytes transmitted in order; overflow=0.
REQ-030 SHALL check overflow:
- Stimulus: seed_ready held high 10 cycles during the first frame, seeds 0x10..0x19.
- Required: 0x10 transmitted, then 0x11..0x14 buffered; drop_count=5; overflow=1; exactly 5 frames sent.
REQ-031 SHALL check push and pop on the same edge at count=4:
- Stimulus: push arriving on the same edge as the STOP-end pop.
- Required: push accepted; count stays 4; drop_count unchanged.
REQ-032 SHALL check reset mid-frame:
- Stimulus: reset=0 during DATA bit 3.
- Required: tx=1, busy=0 and count=0 immediately; after release, a new seed 0x3C transmits correctly.
REQ-033 SHALL check saturation:
- Stimulus: 300 drop events.
- Required: drop_count holds at 255 and does not wrap.
